// File: rtl/monostable_array.sv
// Multi-channel edge detector: optional synchroniser, per-channel glitch filter,
// registered rise/fall/event pulses and sticky pending flags with clear.

package sys_structs;
  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_domain;
endpackage

module monostable_array #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 1
) (
  input  sys_structs::clk_domain  clk_dom_i,
  input  logic [CHANNELS-1:0]     sense_i,
  input  logic [CHANNELS-1:0]     chan_en_i,
  input  logic [2*CHANNELS-1:0]   edge_mode_i,
  input  logic [CHANNELS-1:0]     clear_i,
  output logic [CHANNELS-1:0]     level_o,
  output logic [CHANNELS-1:0]     posedge_o,
  output logic [CHANNELS-1:0]     negedge_o,
  output logic [CHANNELS-1:0]     event_o,
  output logic [CHANNELS-1:0]     pending_o,
  output logic                    any_pending_o
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic clk;
  logic clk_en;
  logic sync_rst;

  assign clk      = clk_dom_i.clk;
  assign clk_en   = clk_dom_i.clk_en;
  assign sync_rst = clk_dom_i.sync_rst;

  // Synchronised view of sense_i that the filter consumes.
  logic [CHANNELS-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = sense_i;
    end else begin : g_sync
      logic [CHANNELS-1:0] stage_q [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (sync_rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            stage_q[k] <= '0;
          end
        end else if (clk_en) begin
          stage_q[0] <= sense_i;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            stage_q[k] <= stage_q[k-1];
          end
        end
      end

      assign s = stage_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [CHANNELS-1:0]            level_q;
  logic [CHANNELS-1:0]            level_d;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_d;
  logic [CHANNELS-1:0]            rise_d;
  logic [CHANNELS-1:0]            fall_d;
  logic [CHANNELS-1:0]            event_d;
  logic [CHANNELS-1:0]            pend_d;
  logic [CHANNELS-1:0]            rise_q;
  logic [CHANNELS-1:0]            fall_q;
  logic [CHANNELS-1:0]            event_q;
  logic [CHANNELS-1:0]            pend_q;

  // A disabled channel tracks s directly so re-enabling cannot see a stale edge.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!chan_en_i[i]) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
      end else if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rise_d  = chan_en_i & level_d & ~level_q;
    fall_d  = chan_en_i & ~level_d & level_q;
    event_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      event_d[i] = (rise_d[i] & edge_mode_i[2*i]) | (fall_d[i] & edge_mode_i[2*i+1]);
    end
    // New event beats a clear arriving in the same cycle.
    pend_d = event_d | (pend_q & ~clear_i);
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      level_q <= '0;
      cnt_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= '0;
      pend_q  <= '0;
    end else if (clk_en) begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
      pend_q  <= pend_d;
    end
  end

  assign level_o       = level_q;
  assign posedge_o     = rise_q;
  assign negedge_o     = fall_q;
  assign event_o       = event_q;
  assign pending_o     = pend_q;
  assign any_pending_o = |pend_q;

endmodule

// File: tb/tb_monostable_array.sv
// Bench for monostable_array: directed scenarios plus random traffic, all checked
// every cycle against a window-based behavioural model.

module tb_monostable_array;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FC = 3;

  logic clk = 1'b0;
  logic clk_en;
  logic sync_rst;
  sys_structs::clk_domain clk_dom;

  logic [CH-1:0]   sense;
  logic [CH-1:0]   chan_en;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clear;
  logic [CH-1:0]   level;
  logic [CH-1:0]   pos;
  logic [CH-1:0]   neg;
  logic [CH-1:0]   evt;
  logic [CH-1:0]   pend;
  logic            any;

  assign clk_dom = '{clk: clk, clk_en: clk_en, sync_rst: sync_rst};

  monostable_array #(
    .CHANNELS(CH),
    .SYNC_STAGES(SS),
    .FILTER_CYCLES(FC)
  ) dut (
    .clk_dom_i(clk_dom),
    .sense_i(sense),
    .chan_en_i(chan_en),
    .edge_mode_i(mode),
    .clear_i(clear),
    .level_o(level),
    .posedge_o(pos),
    .negedge_o(neg),
    .event_o(evt),
    .pending_o(pend),
    .any_pending_o(any)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  // Delay line of enabled-cycle samples; level flips once the last FC samples
  // all disagree with it.
  logic [CH-1:0] mq[$];
  logic [CH-1:0] s_hist[$];
  logic [CH-1:0] m_level, m_pos, m_neg, m_evt, m_pend;

  initial begin
    m_level = '0; m_pos = '0; m_neg = '0; m_evt = '0; m_pend = '0;
    for (int k = 0; k < SS; k++) mq.push_back('0);
  end

  always @(posedge clk) begin : model
    logic [CH-1:0] s_now;
    logic [CH-1:0] nxt;
    bit all_diff;
    if (sync_rst) begin
      m_level = '0; m_pos = '0; m_neg = '0; m_evt = '0; m_pend = '0;
      mq.delete();
      for (int k = 0; k < SS; k++) mq.push_back('0);
      s_hist.delete();
    end else if (clk_en) begin
      if (SS == 0) begin
        s_now = sense;
      end else begin
        s_now = mq.pop_front();
        mq.push_back(sense);
      end
      s_hist.push_back(s_now);
      if (s_hist.size() > FC) void'(s_hist.pop_front());
      nxt = m_level;
      for (int c = 0; c < CH; c++) begin
        if (!chan_en[c]) begin
          nxt[c] = s_now[c];
        end else if (s_hist.size() == FC) begin
          all_diff = 1'b1;
          for (int k = 0; k < FC; k++) if (s_hist[k][c] == m_level[c]) all_diff = 1'b0;
          if (all_diff) nxt[c] = ~m_level[c];
        end
      end
      m_pos = chan_en & nxt & ~m_level;
      m_neg = chan_en & ~nxt & m_level;
      for (int c = 0; c < CH; c++) m_evt[c] = (m_pos[c] & mode[2*c]) | (m_neg[c] & mode[2*c+1]);
      m_pend  = m_evt | (m_pend & ~clear);
      m_level = nxt;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("level", 32'(level), 32'(m_level));
      check("posedge", 32'(pos), 32'(m_pos));
      check("negedge", 32'(neg), 32'(m_neg));
      check("event", 32'(evt), 32'(m_evt));
      check("pending", 32'(pend), 32'(m_pend));
      check("any_pending", 32'(any), 32'(|m_pend));
    end
  end

  // ---------------- driver ----------------
  initial begin
    int cp, cn, ce, cep, cen, en_cnt, seen_at;
    clk_en = 1'b1; sync_rst = 1'b1; sense = '0; chan_en = '1; clear = '0; mode = '1;
    step(2);
    sync_rst = 1'b0;
    chk_on = 1'b1;
    check("rst_level", 32'(level), 32'h0);
    check("rst_pulses", 32'({pos, neg, evt}), 32'h0);
    check("rst_pending", 32'({pend, any}), 32'h0);

    // Latency: 2 sync edges + 3 filter edges.
    sense[0] = 1'b1;
    step(4);
    check("lat_level_early", 32'(level[0]), 32'h0);
    step(1);
    check("lat_level", 32'(level[0]), 32'h1);
    check("lat_pos", 32'(pos[0]), 32'h1);
    check("lat_evt", 32'(evt[0]), 32'h1);
    step(1);
    check("lat_pos_width", 32'(pos[0]), 32'h0);
    check("lat_pend", 32'({pend[0], any}), 32'h3);

    // Set/clear collision on the falling event.
    clear = 4'b0001; step(1); clear = '0;
    check("clr_pend", 32'(pend[0]), 32'h0);
    sense[0] = 1'b0;
    step(4);
    clear = 4'b0001;
    step(1);
    check("coll_neg", 32'({neg[0], evt[0]}), 32'h3);
    check("coll_pend", 32'(pend[0]), 32'h1);
    step(1);
    clear = '0;
    check("coll_clr", 32'({pend, any}), 32'h0);

    // Glitch rejection on ch1.
    sense[1] = 1'b1; step(2); sense[1] = 1'b0;
    cp = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); cp += int'(pos[1]); end
    check("glitch_pos", 32'(cp), 32'h0);
    check("glitch_level", 32'(level[1]), 32'h0);
    sense[1] = 1'b1;
    cp = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); cp += int'(pos[1]); end
    check("accept_pos", 32'(cp), 32'h1);
    check("accept_level", 32'(level[1]), 32'h1);
    sense[1] = 1'b0; step(6);

    // Mode masking on ch2: rising only, then falling only.
    for (int m = 1; m <= 2; m++) begin
      mode = {2'b11, 2'(m), 2'b11, 2'b11};
      cp = 0; cn = 0; ce = 0; cep = 0; cen = 0;
      for (int i = 0; i < 16; i++) begin
        if (i == 0) sense[2] = 1'b1;
        if (i == 8) sense[2] = 1'b0;
        @(negedge clk);
        cp += int'(pos[2]); cn += int'(neg[2]); ce += int'(evt[2]);
        cep += int'(evt[2] & pos[2]); cen += int'(evt[2] & neg[2]);
      end
      check("mode_pos", 32'(cp), 32'h1);
      check("mode_neg", 32'(cn), 32'h1);
      check("mode_evt", 32'(ce), 32'h1);
      check("mode_evt_on_rise", 32'(cep), (m == 1) ? 32'h1 : 32'h0);
      check("mode_evt_on_fall", 32'(cen), (m == 2) ? 32'h1 : 32'h0);
      check("mode_pend", 32'(pend[2]), 32'h1);
      if (m == 1) begin clear = 4'b0100; step(1); clear = '0; end
    end
    mode = '1;

    // clk_en gating: enabled one cycle in three.
    sense[0] = 1'b1; en_cnt = 0; seen_at = -1;
    for (int i = 0; i < 30; i++) begin
      clk_en = (i % 3 == 0);
      @(negedge clk);
      if (clk_en) en_cnt++;
      if (seen_at < 0 && level[0]) begin
        seen_at = i;
        check("gate_latency", 32'(en_cnt), 32'h5);
      end
      if (seen_at >= 0 && i == seen_at + 2) check("gate_pulse_hold", 32'(pos[0]), 32'h1);
    end
    check("gate_seen", 32'(seen_at >= 0), 32'h1);
    clk_en = 1'b1;

    // Reset with clk_en low, mid-filter.
    sense[1] = 1'b1; step(3);
    clk_en = 1'b0; sync_rst = 1'b1;
    step(1);
    check("rst2_level", 32'(level), 32'h0);
    check("rst2_pulses", 32'({pos, neg, evt}), 32'h0);
    check("rst2_pending", 32'({pend, any}), 32'h0);
    sync_rst = 1'b0; clk_en = 1'b1; sense = '0;
    step(6);

    // Disabled channel follows input silently.
    chan_en[3] = 1'b0; sense[3] = 1'b1; cp = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); cp += int'(pos[3]); end
    chan_en = '1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); cp += int'(pos[3]); end
    check("dis_pos", 32'(cp), 32'h0);
    check("dis_level", 32'(level[3]), 32'h1);
    check("dis_pend", 32'(pend[3]), 32'h0);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      clk_en   = ($urandom_range(0, 3) != 0);
      sync_rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) sense[c] = ~sense[c];
        if ($urandom_range(0, 39) == 0) chan_en[c] = ~chan_en[c];
        clear[c] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 29) == 0) mode = 8'($urandom);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
